// File: rtl/imem_boot_loader.sv
// imem_boot_loader: length-prefixed, XOR-checksummed byte stream -> big-endian IMEM byte writes.
// Latency: each accepted data byte is written one cycle later (registered strobe/addr/data).
// Backpressure: in_ready is decoded from the state only; it drops to 0 after the checksum or on error.
//
// Ports:
//   clk, reset            single clock; asynchronous active-high reset
//   in_valid/in_ready     byte-stream handshake, in_data carries the byte
//   im_we/im_addr/im_wdata  registered IMEM byte-lane write port
//   cpu_hold, pc_clear    core stall while loading, one-cycle PC clear on success
//   load_done, err        terminal status flags
//   byte_count            number of data bytes accepted so far
module imem_boot_loader #(
  parameter int IMEM_BYTES = 256,  // multiple of 4, no larger than 2**ADDR_W
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [7:0]        im_wdata,
  output logic              cpu_hold,
  output logic              pc_clear,
  output logic              load_done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [2:0] S_LEN_HI  = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [17:0] MAX_TOTAL = 18'(IMEM_BYTES);

  logic [2:0]        state_q,      state_d;
  logic [7:0]        len_hi_q,     len_hi_d;
  logic [17:0]       total_q,      total_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic [7:0]        csum_q,       csum_d;
  logic              we_q,         we_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [7:0]        wdata_q,      wdata_d;

  logic        accept;
  logic [17:0] total_now;
  logic        last_data;

  // in_ready depends on the state register alone, never on in_valid.
  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept   = in_valid & in_ready;

  // Byte total of the stream being announced: 4 * {high byte, low byte}.
  // Kept at 18 bits so a 16-bit word count can never wrap.
  assign total_now = {len_hi_q, in_data, 2'b00};

  // The byte being accepted in DATA is the final one when count+1 reaches total.
  assign last_data = ((18'(byte_count_q) + 18'd1) == total_q);

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    total_d      = total_q;
    byte_count_d = byte_count_q;
    csum_d       = csum_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d     = in_data;
          // A fresh header always restarts at address 0 with a clean checksum.
          byte_count_d = '0;
          csum_d       = 8'h00;
          state_d      = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          total_d = total_now;
          if (total_now > MAX_TOTAL) begin
            state_d = S_ERROR;
          end else if (total_now == 18'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          we_d         = 1'b1;
          addr_d       = byte_count_q[ADDR_W-1:0];
          wdata_d      = in_data;
          byte_count_d = byte_count_q + 1'b1;
          csum_d       = csum_q ^ in_data;
          if (last_data) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_RELEASE : S_ERROR;
        end
      end

      S_RELEASE: state_d = S_RUN;

      S_RUN:     state_d = S_RUN;

      S_ERROR:   state_d = S_ERROR;

      // Unreachable encodings park the loader with the core held.
      default:   state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LEN_HI;
      len_hi_q     <= 8'h00;
      total_q      <= 18'd0;
      byte_count_q <= '0;
      csum_q       <= 8'h00;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      total_q      <= total_d;
      byte_count_q <= byte_count_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign byte_count = byte_count_q;

  assign cpu_hold   = (state_q != S_RUN);
  assign pc_clear   = (state_q == S_RELEASE);
  assign load_done  = (state_q == S_RUN);
  assign err        = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int IMEM_BYTES = 256;
  localparam int ADDR_W     = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [7:0]        im_wdata;
  logic              cpu_hold;
  logic              pc_clear;
  logic              load_done;
  logic              err;
  logic [ADDR_W:0]   byte_count;

  imem_boot_loader #(.IMEM_BYTES(IMEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .pc_clear   (pc_clear),
    .load_done  (load_done),
    .err        (err),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed IMEM image, rebuilt from the write port.
  logic [7:0] obs_mem [IMEM_BYTES];
  bit         obs_wr  [IMEM_BYTES];
  int         wcount, pcc, last_addr, first_addr;

  always @(negedge clk) begin
    if (im_we) begin
      if (wcount == 0) first_addr = int'(im_addr);
      obs_mem[im_addr] = im_wdata;
      obs_wr[im_addr]  = 1'b1;
      last_addr        = int'(im_addr);
      wcount++;
    end
    if (pc_clear) pcc++;
  end

  // Reference model state.
  logic [7:0] stream [$];
  logic [7:0] exp_mem [IMEM_BYTES];
  bit         exp_ok;
  int         exp_consumed, exp_writes;
  bit         gaps;

  logic [31:0] loop_words [12] = '{
    32'h00000020, 32'h00001020, 32'h20010005, 32'h20420001,
    32'h00411822, 32'h1460FFFD, 32'h00000000, 32'h20050007,
    32'h00A53020, 32'hAC060004, 32'h8C070004, 32'hAC03000B };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < IMEM_BYTES; i++) begin
      obs_mem[i] = 8'h00;
      obs_wr[i]  = 1'b0;
    end
    wcount = 0; pcc = 0; last_addr = -1; first_addr = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Build a stream: header, n words (loop program or random), checksum ^ mask.
  task automatic build(input int n, input bit loop_prog, input logic [7:0] mask);
    logic [31:0] w;
    logic [7:0]  x;
    stream.delete();
    stream.push_back(8'((n >> 8) & 255));
    stream.push_back(8'(n & 255));
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = loop_prog ? loop_words[k] : $urandom;
      for (int b = 3; b >= 0; b--) begin
        stream.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
    stream.push_back(x ^ mask);
  endtask

  // Outcome of the stream, worked out from the format rules alone.
  task automatic model();
    int n, tot;
    logic [7:0] x;
    n   = (int'(stream[0]) << 8) | int'(stream[1]);
    tot = 4 * n;
    if (tot > IMEM_BYTES) begin
      exp_ok = 1'b0; exp_consumed = 2; exp_writes = 0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < tot; i++) begin
        exp_mem[i] = stream[2 + i];
        x ^= stream[2 + i];
      end
      exp_writes   = tot;
      exp_consumed = tot + 3;
      exp_ok       = (stream[2 + tot] == x);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   k;
    in_valid = 1'b1; in_data = b; k = 0;
    forever begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      k++;
      if (k > 50) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0; in_data = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      send_byte(stream[i]);
    end
  endtask

  task automatic finish_check(input string nm);
    if (exp_ok) begin
      check({nm, "_pcclr_pulse"}, 32'(pc_clear), 32'd1);
      check({nm, "_done_early"},  32'(load_done), 32'd0);
      check({nm, "_hold_early"},  32'(cpu_hold), 32'd1);
      @(posedge clk); #1;
      check({nm, "_pcclr_end"},   32'(pc_clear), 32'd0);
      check({nm, "_done"},        32'(load_done), 32'd1);
      check({nm, "_hold"},        32'(cpu_hold), 32'd0);
    end else begin
      check({nm, "_err_rise"},    32'(err), 32'd1);
      check({nm, "_hold"},        32'(cpu_hold), 32'd1);
    end
    check({nm, "_rdy"}, 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk); #1;
    check({nm, "_done_final"}, 32'(load_done), 32'(exp_ok));
    check({nm, "_err_final"},  32'(err), 32'(!exp_ok));
    check({nm, "_pcclr_cnt"},  32'(pcc), 32'(exp_ok));
    check({nm, "_writes"},     32'(wcount), 32'(exp_writes));
    check({nm, "_bytecount"},  32'(byte_count), 32'(exp_writes));
    for (int i = 0; i < exp_writes; i++) begin
      check($sformatf("%s_mem[%0d]", nm, i), 32'(obs_mem[i]), 32'(exp_mem[i]));
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_in_ready"},  32'(in_ready), 32'd1);
    check({nm, "_im_we"},     32'(im_we), 32'd0);
    check({nm, "_im_addr"},   32'(im_addr), 32'd0);
    check({nm, "_im_wdata"},  32'(im_wdata), 32'd0);
    check({nm, "_cpu_hold"},  32'(cpu_hold), 32'd1);
    check({nm, "_pc_clear"},  32'(pc_clear), 32'd0);
    check({nm, "_load_done"}, 32'(load_done), 32'd0);
    check({nm, "_err"},       32'(err), 32'd0);
    check({nm, "_bcount"},    32'(byte_count), 32'd0);
  endtask

  initial begin
    int c0, n;
    logic [7:0] mask;

    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; gaps = 1'b0;
    clear_obs();
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst");
    do_reset();

    // Loop program, back-to-back bytes.
    build(12, 1'b1, 8'h00); model();
    c0 = cyc;
    send_n(exp_consumed);
    check("loop_throughput", 32'(cyc - c0), 32'd51);
    finish_check("loop");
    check("loop_bytes0_3",   {obs_mem[0], obs_mem[1], obs_mem[2], obs_mem[3]}, 32'h00000020);
    check("loop_bytes44_47", {obs_mem[44], obs_mem[45], obs_mem[46], obs_mem[47]}, 32'hAC03000B);
    check("loop_we_total",   32'(wcount), 32'd48);
    check("loop_bcount",     32'(byte_count), 32'd48);

    // Full IMEM.
    do_reset();
    build(64, 1'b0, 8'h00); model();
    send_n(exp_consumed);
    finish_check("full");
    check("full_last_addr", 32'(last_addr), 32'hFF);

    // One word too many.
    do_reset();
    build(65, 1'b0, 8'h00); model();
    send_n(exp_consumed);
    finish_check("over");
    check("over_no_we", 32'(wcount), 32'd0);

    // Bad checksum.
    do_reset();
    build(12, 1'b1, 8'h01); model();
    send_n(exp_consumed);
    finish_check("badck");
    check("badck_pcclr_never", 32'(pcc), 32'd0);
    check("badck_we_total",    32'(wcount), 32'd48);

    // Zero length, good and bad checksum.
    do_reset();
    build(0, 1'b0, 8'h00); model();
    send_n(exp_consumed);
    finish_check("zero");
    do_reset();
    build(0, 1'b0, 8'h5A); model();
    send_n(exp_consumed);
    finish_check("zero_bad");

    // Loop program with random gaps and garbage on in_data.
    do_reset();
    gaps = 1'b1;
    build(12, 1'b1, 8'h00); model();
    send_n(exp_consumed);
    finish_check("gaps");

    // Reset mid-load after header + 10 data bytes, between clock edges.
    do_reset();
    build(12, 1'b1, 8'h00);
    send_n(12);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    clear_obs();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    gaps = 1'b0;
    build(20, 1'b0, 8'h00); model();
    send_n(exp_consumed);
    finish_check("reload");
    check("reload_first_addr", 32'(first_addr), 32'd0);

    // Randomized streams.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      gaps = 1'($urandom_range(0, 1));
      n    = $urandom_range(0, 66);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build(n, 1'b0, mask); model();
      send_n(exp_consumed);
      finish_check($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream program loader for the single-cycle MIPS core's instruction memory. Accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and writes it big-endian into IMEM byte lanes, so each word occupies IM[4k]..IM[4k+3], MSB first. Holds the core stalled while loading, then pulses a PC clear and releases it. Replaces hierarchical IMEM preload for hardware bring-up and gives benches a real load path.

## Interface
- `IMEM_BYTES`, default 256: IMEM size in bytes; must be a multiple of 4 and ≤ 2^ADDR_W.
- `ADDR_W`, default 8: IMEM byte-address width.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1: source has a byte on `in_data`.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle. A transfer occurs on a rising edge with `in_valid & in_ready`.
- `im_we`  out  1: IMEM byte write strobe, one cycle per byte.
- `im_addr`  out  ADDR_W: IMEM byte address.
- `im_wdata`  out  8: IMEM byte data.
- `cpu_hold`  out  1: stalls the core (no PC or register update) while high.
- `pc_clear`  out  1: one-cycle pulse that forces PC to 0.
- `load_done`  out  1: load completed successfully.
- `err`  out  1: load aborted.
- `byte_count`  out  ADDR_W+1: data bytes accepted so far.

## Operation
- Stream format:
  - Word count N as 2 bytes, big-endian (16-bit).
  - Then 4N data bytes.
  - Then 1 checksum byte, equal to the XOR of all data bytes.
- States:
  - `LEN_HI`: reset state. Accept the high count byte, then go to `LEN_LO`.
  - `LEN_LO`: accept the low count byte and compute total = 4N as an 18-bit value. If total > IMEM_BYTES, go to `ERROR`. If total = 0, go to `CHECK`. Otherwise go to `DATA`.
  - `DATA`: each accepted byte is written to address `byte_count`, then `byte_count` increments and the byte is XORed into the running checksum. After byte total−1 is accepted, go to `CHECK`.
  - `CHECK`: accept one byte. If it equals the running checksum, go to `RELEASE`; otherwise go to `ERROR`.
  - `RELEASE`: one cycle with `pc_clear`=1, then go to `RUN`.
  - `RUN`: terminal state. `cpu_hold`=0, `load_done`=1. Stays here until reset.
  - `ERROR`: terminal state. `err`=1, `cpu_hold`=1. Stays here until reset.
- `in_ready` is 1 in `LEN_HI`, `LEN_LO`, `DATA` and `CHECK`, and 0 elsewhere. It is decoded from the state register only, with no combinational path from `in_valid`.
- `in_data` is ignored when `in_valid`=0; gaps of any length are allowed.
- `cpu_hold` is 1 in every state except `RUN`.
- Exactly IMEM_BYTES of data (N = IMEM_BYTES/4) is legal. N = IMEM_BYTES/4 + 1 is an error.
- The running checksum is 8 bits and cleared on reset. For N=0 the expected checksum is 0x00.
- Reset mid-load returns to `LEN_HI` with all outputs at their reset values. IMEM bytes already written are not erased. The next header restarts writing at address 0.

## Timing
- Reset values: `in_ready`=1, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=1, `pc_clear`=0, `load_done`=0, `err`=0, `byte_count`=0.
- `im_we`, `im_addr` and `im_wdata` are registered. The write strobe is asserted in the cycle after the data byte is accepted, for exactly one cycle. The last data byte's write therefore occurs during the first `CHECK` cycle.
- Sustained throughput is 1 byte per cycle with `in_valid` held high.
- `err` rises 1 cycle after the accepting edge of the offending byte: the second length byte, or the checksum byte.
- After a good checksum is accepted (edge E):
  - `pc_clear`=1 for the cycle following E.
  - `load_done`=1 and `cpu_hold`=0 from the next edge onward.
- `byte_count` updates on the accepting edge and holds its final value in `RUN` and `ERROR`.

## Test plan
- **Loop program.** Send header 00 0C, then 48 bytes, starting with words 00000020, 00001020, …, and ending with AC03000B, then the correct XOR. Required:
  - IMEM bytes 0–3 = 00 00 00 20 and bytes 44–47 = AC 03 00 0B.
  - 48 `im_we` pulses total.
  - `byte_count`=48.
  - A single `pc_clear` pulse, then `load_done`=1 and `cpu_hold`=0.
- **Boundary length.**
  - Header 00 40 (256 bytes) with a correct checksum: success, and the last write is at `im_addr`=0xFF.
  - Header 00 41: `err`=1 one cycle after the second header byte, `in_ready`=0, no `im_we` ever asserted.
- **Bad checksum.** The 12-word stream with its checksum XOR 0x01 gives `err`=1, `cpu_hold`=1, `load_done`=0 and `pc_clear` never asserted. All 48 bytes are still written.
- **Zero length.**
  - 00 00 00: RUN within 2 cycles, no writes.
  - 00 00 5A: `err`=1.
- **Backpressure and gaps.** The loop stream with `in_valid` toggled randomly, and `in_data` set to garbage while `in_valid`=0, gives IMEM contents identical to the loop-program scenario.
- **Reset mid-load.**
  - Assert `reset` asynchronously (not on a clock edge) after 10 data bytes: all outputs take their reset values immediately.
  - A following full load starts writing at `im_addr`=0 and succeeds.
